// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the write-back port arbiter: default widths,
// the hard-wired zero register and the buffered entry type.
package wb_port_arbiter_pkg;

    localparam int DATA_W   = 32;
    localparam int REG_AW   = 5;
    localparam int ZERO_REG = 0;

    typedef struct packed {
        logic [REG_AW-1:0] dest;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_hold_buf.sv
// One-entry holding buffer in front of the shared write port.
// Accepts an entry whenever it is empty or being drained this cycle,
// and silently swallows writes aimed at the zero register.
module wb_hold_buf
    import wb_port_arbiter_pkg::*;
#(
    parameter int DATA_W = wb_port_arbiter_pkg::DATA_W,
    parameter int REG_AW = wb_port_arbiter_pkg::REG_AW
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [REG_AW-1:0] In_Dest,
    input  logic [DATA_W-1:0] In_Data,
    input  logic              Drain,
    output logic              Load,
    output logic              Buf_Valid,
    output logic [REG_AW-1:0] Buf_Dest,
    output logic [DATA_W-1:0] Buf_Data
);

    logic              buf_v;
    logic [REG_AW-1:0] buf_dest;
    logic [DATA_W-1:0] buf_data;

    // Ready depends only on buffer state and the grant, never on In_Valid,
    // so a draining buffer can be refilled on the same edge.
    assign In_Ready = !buf_v || Drain;
    assign Load     = In_Valid && In_Ready && (In_Dest != REG_AW'(ZERO_REG));

    // Capture a new entry, or empty the buffer once its entry has been granted.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            buf_v    <= 1'b0;
            buf_dest <= '0;
            buf_data <= '0;
        end else if (Load) begin
            buf_v    <= 1'b1;
            buf_dest <= In_Dest;
            buf_data <= In_Data;
        end else if (Drain) begin
            buf_v    <= 1'b0;
        end
    end

    assign Buf_Valid = buf_v;
    assign Buf_Dest  = buf_dest;
    assign Buf_Data  = buf_data;

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register file write port between the ALU result path and the
// load-return path. Each source owns a one-entry buffer; the older pending
// entry wins the port and is presented on registered outputs.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DATA_W = wb_port_arbiter_pkg::DATA_W,
    parameter int REG_AW = wb_port_arbiter_pkg::REG_AW
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Alu_Valid,
    output logic              Alu_Ready,
    input  logic [REG_AW-1:0] Alu_Dest,
    input  logic [DATA_W-1:0] Alu_Result,
    input  logic              Mem_Valid,
    output logic              Mem_Ready,
    input  logic [REG_AW-1:0] Mem_Dest,
    input  logic [DATA_W-1:0] Read_Data,
    output logic              RegWrite,
    output logic [REG_AW-1:0] WriteReg,
    output logic [DATA_W-1:0] WriteData,
    output logic              Busy
);

    logic              alu_buf_v;
    logic [REG_AW-1:0] alu_buf_dest;
    logic [DATA_W-1:0] alu_buf_data;
    logic              alu_load;
    logic              mem_buf_v;
    logic [REG_AW-1:0] mem_buf_dest;
    logic [DATA_W-1:0] mem_buf_data;
    logic              mem_load;
    logic              grant_alu;
    logic              grant_mem;
    logic              alu_stay;
    logic              mem_stay;
    logic              mem_first;

    wb_hold_buf #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_alu_buf (
        .Clk       (Clk),
        .Rst       (Rst),
        .In_Valid  (Alu_Valid),
        .In_Ready  (Alu_Ready),
        .In_Dest   (Alu_Dest),
        .In_Data   (Alu_Result),
        .Drain     (grant_alu),
        .Load      (alu_load),
        .Buf_Valid (alu_buf_v),
        .Buf_Dest  (alu_buf_dest),
        .Buf_Data  (alu_buf_data)
    );

    wb_hold_buf #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_mem_buf (
        .Clk       (Clk),
        .Rst       (Rst),
        .In_Valid  (Mem_Valid),
        .In_Ready  (Mem_Ready),
        .In_Dest   (Mem_Dest),
        .In_Data   (Read_Data),
        .Drain     (grant_mem),
        .Load      (mem_load),
        .Buf_Valid (mem_buf_v),
        .Buf_Dest  (mem_buf_dest),
        .Buf_Data  (mem_buf_data)
    );

    // Pick the single occupied buffer, or the older one when both are full.
    always_comb begin
        grant_alu = 1'b0;
        grant_mem = 1'b0;
        if (alu_buf_v && mem_buf_v) begin
            grant_mem = mem_first;
            grant_alu = !mem_first;
        end else begin
            grant_alu = alu_buf_v;
            grant_mem = mem_buf_v;
        end
    end

    assign alu_stay = alu_buf_v && !grant_alu;
    assign mem_stay = mem_buf_v && !grant_mem;

    // Track which buffer holds the older entry after this edge: a waiting
    // entry beats a fresh one, and a same-edge pair is ordered mem first.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            mem_first <= 1'b1;
        end else if (alu_stay && mem_load) begin
            mem_first <= 1'b0;
        end else if (mem_stay && alu_load) begin
            mem_first <= 1'b1;
        end else if (alu_load && mem_load) begin
            mem_first <= 1'b1;
        end
    end

    // Register the granted write; address and data hold when idle.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            RegWrite  <= 1'b0;
            WriteReg  <= '0;
            WriteData <= '0;
        end else if (grant_mem) begin
            RegWrite  <= 1'b1;
            WriteReg  <= mem_buf_dest;
            WriteData <= mem_buf_data;
        end else if (grant_alu) begin
            RegWrite  <= 1'b1;
            WriteReg  <= alu_buf_dest;
            WriteData <= alu_buf_data;
        end else begin
            RegWrite  <= 1'b0;
        end
    end

    assign Busy = alu_buf_v || mem_buf_v;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: an age-ordered queue model of the
// pending writes is compared against the DUT every cycle, plus directed
// literal expectations for each scenario.
module tb_wb_port_arbiter;
    import wb_port_arbiter_pkg::*;

    logic              Clk = 1'b0;
    logic              Rst;
    logic              Alu_Valid;
    logic              Alu_Ready;
    logic [REG_AW-1:0] Alu_Dest;
    logic [DATA_W-1:0] Alu_Result;
    logic              Mem_Valid;
    logic              Mem_Ready;
    logic [REG_AW-1:0] Mem_Dest;
    logic [DATA_W-1:0] Read_Data;
    logic              RegWrite;
    logic [REG_AW-1:0] WriteReg;
    logic [DATA_W-1:0] WriteData;
    logic              Busy;

    wb_port_arbiter #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Alu_Valid  (Alu_Valid),
        .Alu_Ready  (Alu_Ready),
        .Alu_Dest   (Alu_Dest),
        .Alu_Result (Alu_Result),
        .Mem_Valid  (Mem_Valid),
        .Mem_Ready  (Mem_Ready),
        .Mem_Dest   (Mem_Dest),
        .Read_Data  (Read_Data),
        .RegWrite   (RegWrite),
        .WriteReg   (WriteReg),
        .WriteData  (WriteData),
        .Busy       (Busy)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;
    logic check_en = 1'b0;
    logic log_en = 1'b0;
    logic [DATA_W-1:0] shadow [32];
    logic [DATA_W-1:0] wlog [$];

    // Pending writes in age order; the head always owns the port.
    typedef struct {
        logic      is_mem;
        wb_entry_t e;
    } pend_t;
    pend_t pend_q [$];

    logic              exp_rw = 1'b0;
    logic [REG_AW-1:0] exp_wr = '0;
    logic [DATA_W-1:0] exp_wd = '0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // A source may hand over a new entry if it has nothing pending or its
    // pending entry is the oldest and therefore leaves this cycle.
    function automatic logic srcReady(input logic is_mem);
        for (int i = 0; i < pend_q.size(); i++)
            if (pend_q[i].is_mem == is_mem) return (i == 0);
        return 1'b1;
    endfunction

    // Reference model advanced once per rising edge.
    initial begin
        pend_t p;
        logic a_rdy, m_rdy;
        forever begin
            @(posedge Clk);
            if (Rst) begin
                pend_q.delete();
                exp_rw = 1'b0;
                exp_wr = '0;
                exp_wd = '0;
            end else begin
                a_rdy = srcReady(1'b0);
                m_rdy = srcReady(1'b1);
                if (pend_q.size() > 0) begin
                    p = pend_q.pop_front();
                    exp_rw = 1'b1;
                    exp_wr = p.e.dest;
                    exp_wd = p.e.data;
                end else begin
                    exp_rw = 1'b0;
                end
                if (Mem_Valid && m_rdy && Mem_Dest != 0) begin
                    p.is_mem = 1'b1;
                    p.e.dest = Mem_Dest;
                    p.e.data = Read_Data;
                    pend_q.push_back(p);
                end
                if (Alu_Valid && a_rdy && Alu_Dest != 0) begin
                    p.is_mem = 1'b0;
                    p.e.dest = Alu_Dest;
                    p.e.data = Alu_Result;
                    pend_q.push_back(p);
                end
            end
        end
    end

    // Compare every output against the model on each falling edge and
    // record the writes the DUT actually performs.
    initial begin
        for (int i = 0; i < 32; i++) shadow[i] = '0;
        forever begin
            @(negedge Clk);
            if (check_en) begin
                checkOutput("RegWrite",  32'(RegWrite),  32'(exp_rw));
                checkOutput("WriteReg",  32'(WriteReg),  32'(exp_wr));
                checkOutput("WriteData", WriteData,      exp_wd);
                checkOutput("Busy",      32'(Busy),      32'(pend_q.size() != 0));
                checkOutput("Alu_Ready", 32'(Alu_Ready), 32'(srcReady(1'b0)));
                checkOutput("Mem_Ready", 32'(Mem_Ready), 32'(srcReady(1'b1)));
            end
            if (RegWrite === 1'b1) begin
                shadow[WriteReg] = WriteData;
                if (log_en) wlog.push_back(WriteData);
            end
        end
    end

    // Drive one cycle of inputs, let one rising edge pass, return just after it.
    task automatic applyStimulus(input logic rst,
                                 input logic av, input logic [4:0] ad, input logic [31:0] adata,
                                 input logic mv, input logic [4:0] md, input logic [31:0] mdata);
        Rst        = rst;
        Alu_Valid  = av;
        Alu_Dest   = ad;
        Alu_Result = adata;
        Mem_Valid  = mv;
        Mem_Dest   = md;
        Read_Data  = mdata;
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        // Reset with both sources offering entries that must be dropped.
        applyStimulus(1'b1, 1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
        applyStimulus(1'b1, 1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
        checkOutput("rst_RegWrite",  32'(RegWrite),  32'd0);
        checkOutput("rst_Busy",      32'(Busy),      32'd0);
        checkOutput("rst_Alu_Ready", 32'(Alu_Ready), 32'd1);
        checkOutput("rst_Mem_Ready", 32'(Mem_Ready), 32'd1);
        checkOutput("rst_WriteReg",  32'(WriteReg),  32'd0);
        checkOutput("rst_WriteData", WriteData,      32'd0);
        check_en = 1'b1;
        idle();
        checkOutput("rst_no_write", 32'(RegWrite), 32'd0);

        // Single ALU write appears two edges after acceptance for one cycle.
        applyStimulus(1'b0, 1'b1, 5'd3, 32'd1, 1'b0, 5'd0, 32'd0);
        checkOutput("single_early", 32'(RegWrite), 32'd0);
        idle();
        checkOutput("single_rw",   32'(RegWrite), 32'd1);
        checkOutput("single_reg",  32'(WriteReg), 32'd3);
        checkOutput("single_data", WriteData,     32'd1);
        idle();
        checkOutput("single_pulse", 32'(RegWrite), 32'd0);
        checkOutput("single_hold",  32'(WriteReg), 32'd3);

        // Same-edge acceptance: mem goes first, ALU waits one cycle.
        applyStimulus(1'b0, 1'b1, 5'd5, 32'd1, 1'b1, 5'd6, 32'd2);
        checkOutput("simul_alu_rdy", 32'(Alu_Ready), 32'd0);
        checkOutput("simul_mem_rdy", 32'(Mem_Ready), 32'd1);
        idle();
        checkOutput("simul_reg1",  32'(WriteReg), 32'd6);
        checkOutput("simul_data1", WriteData,     32'd2);
        checkOutput("simul_alu_rdy2", 32'(Alu_Ready), 32'd1);
        idle();
        checkOutput("simul_rw2",   32'(RegWrite), 32'd1);
        checkOutput("simul_reg2",  32'(WriteReg), 32'd5);
        checkOutput("simul_data2", WriteData,     32'd1);
        idle();

        // Held ALU entry is older than a mem entry arriving later, same dest.
        applyStimulus(1'b0, 1'b1, 5'd7, 32'h70, 1'b1, 5'd4, 32'h10);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0,  1'b1, 5'd7, 32'h77);
        checkOutput("held_reg0", 32'(WriteReg), 32'd4);
        idle();
        checkOutput("held_reg1",  32'(WriteReg), 32'd7);
        checkOutput("held_data1", WriteData,     32'h70);
        idle();
        checkOutput("held_data2", WriteData,     32'h77);
        idle();
        checkOutput("held_final_r7", shadow[7], 32'h77);

        // Zero-register write is accepted and thrown away.
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD);
        checkOutput("zero_busy", 32'(Busy), 32'd0);
        checkOutput("zero_rdy",  32'(Mem_Ready), 32'd1);
        idle();
        checkOutput("zero_rw", 32'(RegWrite), 32'd0);
        idle();

        // Back-to-back ALU stream of eight writes.
        wlog.delete();
        log_en = 1'b1;
        for (int k = 1; k <= 8; k++)
            applyStimulus(1'b0, 1'b1, 5'd9, 32'(k), 1'b0, 5'd0, 32'd0);
        idle();
        idle();
        idle();
        log_en = 1'b0;
        checkOutput("stream_count", 32'(wlog.size()), 32'd8);
        for (int k = 0; k < wlog.size(); k++)
            checkOutput("stream_order", wlog[k], 32'(k + 1));

        // Same stream cut by reset when the fourth write would go out.
        wlog.delete();
        log_en = 1'b1;
        for (int k = 1; k <= 5; k++)
            applyStimulus(k == 5, 1'b1, 5'd9, 32'(k), 1'b0, 5'd0, 32'd0);
        checkOutput("sreset_rw",   32'(RegWrite), 32'd0);
        checkOutput("sreset_busy", 32'(Busy),     32'd0);
        idle();
        idle();
        idle();
        log_en = 1'b0;
        checkOutput("sreset_count", 32'(wlog.size()), 32'd3);
        for (int k = 0; k < wlog.size(); k++)
            checkOutput("sreset_order", wlog[k], 32'(k + 1));

        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the register file's single write port between the ALU result path and the memory load-return path. Each source has a one-entry holding buffer with a valid/ready handshake, and the port is granted to the older pending entry. The selected write is presented on registered outputs one cycle after grant. The block sits in front of the register file write port and replaces the write-back select mux.

## Interface
Parameters:
- DATA_W, 32, write-data width
- REG_AW, 5, register address width

Ports:
- Clk, in, 1, rising-edge clock
- Rst, in, 1, synchronous, active-high reset
- Alu_Valid, in, 1, ALU result offered
- Alu_Ready, out, 1, ALU result accepted when Alu_Valid && Alu_Ready at an edge
- Alu_Dest, in, REG_AW, ALU destination register
- Alu_Result, in, DATA_W, ALU result value
- Mem_Valid, in, 1, load data offered
- Mem_Ready, out, 1, load data accepted when Mem_Valid && Mem_Ready at an edge
- Mem_Dest, in, REG_AW, load destination register
- Read_Data, in, DATA_W, load data value
- RegWrite, out, 1, register file write enable (registered)
- WriteReg, out, REG_AW, register file write address (registered)
- WriteData, out, DATA_W, register file write data (registered)
- Busy, out, 1, at least one holding buffer is occupied

## Operation
- Per-source buffer state: `buf_v`, `buf_dest`, `buf_data`.
- Grant (combinational from buffer state only):
  - only one `buf_v` set → grant that source;
  - both set → grant the older entry, per the flag `mem_first`;
  - neither set → no grant.
- A granted buffer drains at the next edge.
- Ready rule: `X_Ready = !bufX_v || grantX`. A buffer drained and refilled on the same edge is legal.
  - Ready does not depend on the Valid inputs (no combinational Valid→Ready path).
- Capture: on an edge with `X_Valid && X_Ready`:
  - if dest ≠ 0, load the buffer;
  - if dest == 0, complete the handshake but discard the entry. The buffer stays empty and the entry never reaches the port.
- Age flag `mem_first` is evaluated from post-edge occupancy. The rules, in priority order:
  1. An entry that stays in its buffer across the edge is older than any entry captured on that edge.
  2. If both entries are captured on the same edge, mem is older: `mem_first = 1`.
  3. Otherwise `mem_first` holds its value.
- Output register at each edge:
  - with a grant: RegWrite ← 1, WriteReg ← granted dest, WriteData ← granted data;
  - without a grant: RegWrite ← 0, and WriteReg/WriteData hold.
- Busy = `alu_buf_v || mem_buf_v`.

## Timing
- Reset (Rst high at an edge):
  - all buffers invalid, `mem_first` ← 1;
  - RegWrite ← 0, WriteReg ← 0, WriteData ← 0;
  - Alu_Ready = Mem_Ready = 1, Busy = 0 from the following cycle.
  - Entries offered during the reset edge are discarded.
  - Reset mid-operation drops both buffered entries with no write.
- Latency:
  - Accept at edge N → earliest RegWrite high during cycle N+1..N+2, i.e. captured at N, granted N+1, written to the output register at the N+1 edge.
  - Minimum latency: 2 edges from accept to the output register.
- Throughput: one write per cycle sustained from a single source streaming back-to-back, using drain and refill on the same edge.
- Contention:
  - With both buffers full, the older entry writes first and the younger waits exactly one cycle.
  - The younger source's Ready stays low for that cycle.
- Same-destination ordering: writes to one register leave in acceptance order. Same-edge acceptance is resolved mem-first.
- No starvation: an entry waits at most one cycle after becoming eligible.

## Structure
- Shared package:
  - constants DATA_W and REG_AW;
  - constant ZERO_REG = 0;
  - typedef `wb_entry_t {dest, data}`.
- Sub-module `wb_hold_buf`: one-entry valid/dest/data register with capture, drain and zero-register discard. Instantiated twice.
- Top level contains the grant and age logic and the output register.

## Test plan
- Reset: assert Rst for 2 cycles with both Valid high → no RegWrite, Busy = 0, both Ready = 1, WriteReg/WriteData = 0.
- Single ALU write: Alu_Valid for 1 cycle, dest 3, data 1 → RegWrite pulse of exactly 1 cycle, 2 edges after accept, with WriteReg = 3, WriteData = 1.
- Simultaneous accept: ALU {dest 5, data 1} and Mem {dest 6, data 2} on the same edge → WriteReg 6/WriteData 2, then WriteReg 5/WriteData 1 on consecutive cycles. Alu_Ready low for 1 cycle.
- Held-older case: ALU entry held while the port is blocked, then Mem arrives → ALU writes before Mem, even with both having dest 7. The final value of register 7 is Mem's.
- Zero-register discard: Mem_Valid, dest 0, data 32'hDEAD → handshake completes, Busy stays 0, no RegWrite.
- Streaming and reset: ALU valid 8 consecutive cycles with data 1..8 → 8 back-to-back writes in order with Alu_Ready always 1. Repeat with Rst asserted at write 4 → writes stop and buffers clear; no stale write after reset.
